// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard/stall controller.
// Holds the FSM state encoding, the hardwired-zero register index and the default mul/div latency.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MULDIV_LAT_DEF = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational register-dependency check between the ID instruction and the EX/MEM producers.
// Covers load-use hazards and ID-stage branch operand hazards; $0 never matches.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_branch,
  input  logic       i_idex_memread,
  input  logic       i_idex_regwrite,
  input  logic [4:0] i_idex_rd,
  input  logic       i_exmem_memread,
  input  logic [4:0] i_exmem_rd,
  output logic       o_stall
);

  logic w_idex_match;
  logic w_exmem_match;

  assign w_idex_match  = (i_idex_rd != REG_ZERO) &&
                         ((i_idex_rd == i_id_rs) || (i_idex_rd == i_id_rt));
  assign w_exmem_match = (i_exmem_rd != REG_ZERO) &&
                         ((i_exmem_rd == i_id_rs) || (i_exmem_rd == i_id_rt));

  // Branches compare in ID, so they also wait on ALU results still in EX and on loads in MEM.
  assign o_stall = (i_idex_memread && w_idex_match) ||
                   (i_id_branch && i_idex_regwrite && w_idex_match) ||
                   (i_id_branch && i_exmem_memread && w_exmem_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall controller: memory freeze, mul/div hold FSM, dependency stalls and
// branch/jump redirect flushes, plus a free-running counter of cycles with the PC held.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int word       = 32,
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ID_rs,
  input  logic [4:0]      ID_rt,
  input  logic            ID_branch,
  input  logic            ID_taken,
  input  logic            ID_jump,
  input  logic            IDEX_memread,
  input  logic            IDEX_regwrite,
  input  logic [4:0]      IDEX_rd,
  input  logic            EXMEM_memread,
  input  logic [4:0]      EXMEM_rd,
  input  logic            EX_muldiv,
  input  logic            mem_busy,
  output logic            PC_write,
  output logic            IFID_write,
  output logic            IF_flush,
  output logic            IDEX_write,
  output logic            IDEX_flush,
  output logic            EXMEM_write,
  output logic            EXMEM_flush,
  output logic            MEMWB_write,
  output logic            muldiv_busy,
  output logic [word-1:0] stall_cycles
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ignore;
  logic [word-1:0]   r_stall_cycles;

  logic w_stall;
  logic w_md_hold;
  logic w_redirect;

  hazard_detect u_hazard_detect (
    .i_id_rs         (ID_rs),
    .i_id_rt         (ID_rt),
    .i_id_branch     (ID_branch),
    .i_idex_memread  (IDEX_memread),
    .i_idex_regwrite (IDEX_regwrite),
    .i_idex_rd       (IDEX_rd),
    .i_exmem_memread (EXMEM_memread),
    .i_exmem_rd      (EXMEM_rd),
    .o_stall         (w_stall)
  );

  // r_ignore masks EX_muldiv for the release cycle so the finishing op cannot re-arm the FSM.
  assign w_md_hold  = (r_state == MULDIV) || (EX_muldiv && !r_ignore);
  assign w_redirect = ID_jump || (ID_branch && ID_taken);

  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IF_flush    = 1'b0;
    IDEX_write  = 1'b1;
    IDEX_flush  = 1'b0;
    EXMEM_write = 1'b1;
    EXMEM_flush = 1'b0;
    MEMWB_write = 1'b1;
    if (mem_busy) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_write = 1'b0;
      MEMWB_write = 1'b0;
    end else if (w_md_hold) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_flush = 1'b1;
    end else if (w_stall) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IDEX_flush = 1'b1;
    end else if (w_redirect) begin
      IF_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_ignore       <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (!PC_write) begin
        r_stall_cycles <= r_stall_cycles + word'(1);
      end
      // A memory freeze holds the whole FSM, including the release-cycle mask.
      if (!mem_busy) begin
        r_ignore <= 1'b0;
        case (r_state)
          RUN: begin
            if (EX_muldiv && !r_ignore) begin
              r_state <= MULDIV;
              r_cnt   <= CNT_W'(MULDIV_LAT - 1);
            end
          end
          MULDIV: begin
            if (r_cnt == CNT_W'(1)) begin
              r_state  <= RUN;
              r_cnt    <= '0;
              r_ignore <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign muldiv_busy  = (r_state == MULDIV);
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl with hand sequences for the
// multi-cycle mul/div hold, memory freeze, deferred redirect and mid-hold reset.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_rs, ID_rt, IDEX_rd, EXMEM_rd;
  logic        ID_branch, ID_taken, ID_jump;
  logic        IDEX_memread, IDEX_regwrite, EXMEM_memread;
  logic        EX_muldiv, mem_busy;
  logic        PC_write, IFID_write, IF_flush, IDEX_write, IDEX_flush;
  logic        EXMEM_write, EXMEM_flush, MEMWB_write, muldiv_busy;
  logic [31:0] stall_cycles;
  logic [7:0]  outs;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_stall = '0;

  // {PC, IFID, IF_flush, IDEX_w, IDEX_flush, EXMEM_w, EXMEM_flush, MEMWB}
  localparam logic [7:0] E_DEF = 8'b1101_0101;
  localparam logic [7:0] E_STL = 8'b0001_1101;
  localparam logic [7:0] E_RED = 8'b1111_0101;
  localparam logic [7:0] E_FRZ = 8'b0000_0000;
  localparam logic [7:0] E_MD  = 8'b0000_0111;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.word(32), .MULDIV_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_branch(ID_branch), .ID_taken(ID_taken), .ID_jump(ID_jump),
    .IDEX_memread(IDEX_memread), .IDEX_regwrite(IDEX_regwrite), .IDEX_rd(IDEX_rd),
    .EXMEM_memread(EXMEM_memread), .EXMEM_rd(EXMEM_rd),
    .EX_muldiv(EX_muldiv), .mem_busy(mem_busy),
    .PC_write(PC_write), .IFID_write(IFID_write), .IF_flush(IF_flush),
    .IDEX_write(IDEX_write), .IDEX_flush(IDEX_flush),
    .EXMEM_write(EXMEM_write), .EXMEM_flush(EXMEM_flush), .MEMWB_write(MEMWB_write),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  assign outs = {PC_write, IFID_write, IF_flush, IDEX_write, IDEX_flush,
                 EXMEM_write, EXMEM_flush, MEMWB_write};

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       tk;
    logic       jp;
    logic       idex_mr;
    logic       idex_rw;
    logic [4:0] idex_rd;
    logic       exmem_mr;
    logic [4:0] exmem_rd;
    logic       busy;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic br,
                              input logic tk, input logic jp, input logic imr, input logic irw,
                              input logic [4:0] ird, input logic emr, input logic [4:0] erd,
                              input logic busy, input logic [7:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.br = br; v.tk = tk; v.jp = jp;
    v.idex_mr = imr; v.idex_rw = irw; v.idex_rd = ird;
    v.exmem_mr = emr; v.exmem_rd = erd; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_branch = 1'b0; ID_taken = 1'b0; ID_jump = 1'b0;
    IDEX_memread = 1'b0; IDEX_regwrite = 1'b0; IDEX_rd = 5'd0;
    EXMEM_memread = 1'b0; EXMEM_rd = 5'd0; EX_muldiv = 1'b0; mem_busy = 1'b0;
  endtask

  // Called at a falling edge after inputs are set; checks mid-cycle, advances to the next falling edge.
  task automatic check_cyc(input string nm, input logic [7:0] eo, input logic eb);
    #2;
    check({nm, ".outs"}, 32'(outs), 32'(eo));
    check({nm, ".busy"}, 32'(muldiv_busy), 32'(eb));
    check({nm, ".stall"}, stall_cycles, exp_stall);
    $display("[TB] %s outs=%b busy=%0d stall=%0d", nm, outs, muldiv_busy, stall_cycles);
    if (!eo[7]) exp_stall = exp_stall + 32'd1;
    @(negedge clk);
  endtask

  initial begin
    //             rs     rt     br tk jp imr irw ird    emr erd    busy exp
    vecs[0]  = mk(5'd0,  5'd0,  0, 0, 0, 0,  0,  5'd0,  0,  5'd0,  0,   E_DEF);
    vecs[1]  = mk(5'd5,  5'd0,  0, 0, 0, 1,  1,  5'd5,  0,  5'd0,  0,   E_STL);
    vecs[2]  = mk(5'd0,  5'd0,  0, 0, 0, 1,  1,  5'd0,  0,  5'd0,  0,   E_DEF);
    vecs[3]  = mk(5'd1,  5'd5,  0, 0, 0, 1,  1,  5'd5,  0,  5'd0,  0,   E_STL);
    vecs[4]  = mk(5'd5,  5'd0,  0, 0, 0, 0,  1,  5'd5,  0,  5'd0,  0,   E_DEF);
    vecs[5]  = mk(5'd2,  5'd7,  1, 0, 0, 0,  1,  5'd7,  0,  5'd0,  0,   E_STL);
    vecs[6]  = mk(5'd2,  5'd8,  1, 0, 0, 0,  0,  5'd0,  1,  5'd8,  0,   E_STL);
    vecs[7]  = mk(5'd2,  5'd3,  1, 1, 0, 0,  1,  5'd9,  1,  5'd8,  0,   E_RED);
    vecs[8]  = mk(5'd0,  5'd0,  0, 0, 1, 0,  0,  5'd0,  0,  5'd0,  0,   E_RED);
    vecs[9]  = mk(5'd8,  5'd3,  1, 1, 0, 0,  0,  5'd0,  1,  5'd8,  0,   E_STL);
    vecs[10] = mk(5'd5,  5'd0,  0, 0, 0, 1,  1,  5'd5,  0,  5'd0,  1,   E_FRZ);
    vecs[11] = mk(5'd0,  5'd0,  0, 0, 1, 0,  0,  5'd0,  0,  5'd0,  1,   E_FRZ);
    vecs[12] = mk(5'd8,  5'd0,  0, 0, 0, 0,  0,  5'd0,  1,  5'd8,  0,   E_DEF);
    vecs[13] = mk(5'd0,  5'd0,  1, 0, 0, 0,  1,  5'd0,  1,  5'd0,  0,   E_DEF);
    vecs[14] = mk(5'd4,  5'd6,  1, 0, 0, 0,  0,  5'd6,  0,  5'd0,  0,   E_DEF);

    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("reset.outs", 32'(outs), 32'(E_DEF));
    check("reset.busy", 32'(muldiv_busy), 32'd0);
    check("reset.stall", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      ID_rs = vecs[i].rs; ID_rt = vecs[i].rt;
      ID_branch = vecs[i].br; ID_taken = vecs[i].tk; ID_jump = vecs[i].jp;
      IDEX_memread = vecs[i].idex_mr; IDEX_regwrite = vecs[i].idex_rw; IDEX_rd = vecs[i].idex_rd;
      EXMEM_memread = vecs[i].exmem_mr; EXMEM_rd = vecs[i].exmem_rd;
      mem_busy = vecs[i].busy; EX_muldiv = 1'b0;
      check_cyc($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
    end

    // Mul/div hold: EX_muldiv kept high through the release cycle must not restart.
    clear_inputs();
    EX_muldiv = 1'b1;
    check_cyc("md.c1", E_MD, 1'b0);
    for (int c = 2; c <= 4; c++) check_cyc($sformatf("md.c%0d", c), E_MD, 1'b1);
    check_cyc("md.rel", E_DEF, 1'b0);
    EX_muldiv = 1'b0;
    check_cyc("md.idle", E_DEF, 1'b0);

    // Memory freeze in the middle of the hold stretches it by the frozen cycles.
    EX_muldiv = 1'b1;
    check_cyc("mdf.c1", E_MD, 1'b0);
    check_cyc("mdf.c2", E_MD, 1'b1);
    mem_busy = 1'b1;
    for (int c = 0; c < 3; c++) check_cyc($sformatf("mdf.frz%0d", c), E_FRZ, 1'b1);
    mem_busy = 1'b0;
    check_cyc("mdf.c3", E_MD, 1'b1);
    check_cyc("mdf.c4", E_MD, 1'b1);
    check_cyc("mdf.rel", E_DEF, 1'b0);
    EX_muldiv = 1'b0;
    check_cyc("mdf.idle", E_DEF, 1'b0);

    // Taken branch under a freeze: redirect appears only once memory is ready.
    ID_branch = 1'b1; ID_taken = 1'b1; mem_busy = 1'b1;
    check_cyc("brb.busy0", E_FRZ, 1'b0);
    check_cyc("brb.busy1", E_FRZ, 1'b0);
    mem_busy = 1'b0;
    check_cyc("brb.go", E_RED, 1'b0);
    clear_inputs();
    check_cyc("brb.idle", E_DEF, 1'b0);

    // Asynchronous reset mid-hold.
    EX_muldiv = 1'b1;
    check_cyc("rst.c1", E_MD, 1'b0);
    check_cyc("rst.c2", E_MD, 1'b1);
    EX_muldiv = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.async.outs", 32'(outs), 32'(E_DEF));
    check("rst.async.busy", 32'(muldiv_busy), 32'd0);
    check("rst.async.stall", stall_cycles, 32'd0);
    exp_stall = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cyc("rst.after", E_DEF, 1'b0);
    IDEX_memread = 1'b1; IDEX_rd = 5'd5; ID_rs = 5'd5;
    check_cyc("rst.lu", E_STL, 1'b0);
    clear_inputs();
    check_cyc("rst.idle", E_DEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage MIPS pipeline.
- Drives write-enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles four cases: load-use stalls, ID-stage branch operand stalls, taken-branch/jump flushes, and two multi-cycle hold sources.
- The multi-cycle hold sources are an EX-stage mul/div unit (FSM plus counter) and a data-memory busy freeze; a free-running stall-cycle counter is provided for performance monitoring.

Parameters:
- word, 32, datapath width; width of the stall counter.
- MULDIV_LAT, 4, total EX occupancy of a mul/div op in cycles, including the start cycle; legal range is 2 to 16.
- CNT_W, 4, width of the mul/div down-counter; must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_branch  in  1  ID instruction is beq/bne (compare done in ID).
- ID_taken  in  1  branch condition true in ID (valid with ID_branch).
- ID_jump  in  1  ID instruction is j/jal/jr.
- IDEX_memread  in  1  EX-stage instruction is a load.
- IDEX_regwrite  in  1  EX-stage instruction writes the register file.
- IDEX_rd  in  5  EX-stage destination register (already muxed rt/rd).
- EXMEM_memread  in  1  MEM-stage instruction is a load.
- EXMEM_rd  in  5  MEM-stage destination register.
- EX_muldiv  in  1  EX-stage instruction is mult/div (level, qualified by the FSM).
- mem_busy  in  1  data memory cannot complete this cycle.
- PC_write  out  1  PC load enable.
- IFID_write  out  1  IF/ID load enable.
- IF_flush  out  1  zero IF/ID on this edge.
- IDEX_write  out  1  ID/EX load enable.
- IDEX_flush  out  1  load a bubble (zero controls) into ID/EX.
- EXMEM_write  out  1  EX/MEM load enable.
- EXMEM_flush  out  1  load a bubble into EX/MEM.
- MEMWB_write  out  1  MEM/WB load enable.
- muldiv_busy  out  1  FSM in MULDIV state.
- stall_cycles  out  word  count of cycles with PC_write=0.

Behaviour:
- States: RUN and MULDIV. A CNT_W-bit down-counter cnt is used in MULDIV.
- Outputs are combinational from state and inputs; state, cnt and stall_cycles are registered.
- Reset (async, rst_n=0): state=RUN, cnt=0, stall_cycles=0. Outputs then follow the RUN decode of the current inputs.
- Default (no condition below active): all *_write=1, all *_flush=0.
- Evaluate the following in priority order, highest first.
- 1. Freeze when mem_busy=1 (any state):
  - All *_write=0 and all *_flush=0.
  - The FSM and cnt hold.
  - A pending branch flush is deferred until mem_busy=0.
- 2. Mul/div hold when state=MULDIV, or when state=RUN and EX_muldiv=1:
  - PC_write=0, IFID_write=0, IDEX_write=0.
  - EXMEM_write=1 with EXMEM_flush=1 (bubble into MEM).
  - MEMWB_write=1, IF_flush=0, IDEX_flush=0.
- 3. Define match(r) = (r != 0) && (r==ID_rs || r==ID_rt). A stall is required when any of these holds:
  - IDEX_memread && match(IDEX_rd) (load-use);
  - ID_branch && IDEX_regwrite && match(IDEX_rd);
  - ID_branch && EXMEM_memread && match(EXMEM_rd).
  On a stall: PC_write=0, IFID_write=0, IDEX_flush=1, IF_flush=0.
- 4. Redirect: if ID_jump, or ID_branch && ID_taken, then IF_flush=1; all writes remain 1.
- FSM transitions:
  - RUN with EX_muldiv=1 and mem_busy=0: go to MULDIV, cnt <= MULDIV_LAT-1.
  - MULDIV with mem_busy=0: if cnt==1, go to RUN; otherwise cnt <= cnt-1.
  - The hold lasts exactly MULDIV_LAT unfrozen cycles.
  - On the release cycle (state back in RUN), the op has advanced; EX_muldiv is ignored for one cycle after the MULDIV-to-RUN transition, so the same op does not restart.
- stall_cycles increments, wrapping modulo 2^word, on every edge where PC_write=0 in the pre-edge cycle.
- Register $0 never causes a hazard.
- Reset asserted mid-MULDIV aborts immediately to RUN.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (RUN=1'b0, MULDIV=1'b1);
  - REG_ZERO=5'd0;
  - the MULDIV_LAT default.
- One natural sub-module, hazard_detect: purely combinational match/stall decode of priority 3.
- The FSM, counter and output priority mux stay in the top module.

Test Plan:
- Load-use: IDEX_memread=1, IDEX_rd=5, ID_rs=5 for one cycle -> PC_write=0, IFID_write=0, IDEX_flush=1 that cycle; stall_cycles=1 after the edge. With IDEX_rd=0 -> no stall.
- Branch operand hazards: ID_branch=1, ID_rt=8, EXMEM_memread=1, EXMEM_rd=8 -> stall. Next cycle no match, with ID_taken=1 -> IF_flush=1 and all writes 1.
- Mul/div with MULDIV_LAT=4: EX_muldiv pulse in RUN -> exactly 4 consecutive cycles of PC_write=0, EXMEM_flush=1. muldiv_busy=1 for cycles 2-4, then RUN with no restart; stall_cycles=4.
- mem_busy for 3 cycles during MULDIV with cnt=2 -> all writes 0 and cnt frozen at 2; the hold resumes after and ends after 2 more cycles (total hold = 4 unfrozen + 3 frozen).
- Taken branch with mem_busy=1 -> IF_flush=0 while busy; IF_flush=1 on the first cycle mem_busy=0.
- rst_n low for 1 cycle mid-MULDIV (cnt=2) -> state RUN and cnt=0 asynchronously, stall_cycles=0, outputs show the default enables.
